// File: rtl/trap_pkg.sv
// Shared types and constants for the supervisor trap controller.
// Imported by the CSR file and the sequencing FSM.
package trap_pkg;

  typedef enum logic [2:0] {
    IDLE,
    T_FLUSH,
    T_REDIR,
    R_FLUSH,
    R_REDIR
  } state_t;

  localparam logic [11:0] SSTATUS = 12'h100;
  localparam logic [11:0] STVEC   = 12'h105;
  localparam logic [11:0] SEPC    = 12'h141;
  localparam logic [11:0] SCAUSE  = 12'h142;

  localparam int SIE_BIT  = 1;
  localparam int SPIE_BIT = 5;

  localparam logic [7:0] ECALL     = 8'h08;
  localparam logic [7:0] ILLEGAL   = 8'h02;
  localparam logic [7:0] MISALIGN  = 8'h00;
  localparam logic [7:0] IRQ_CAUSE = 8'h89;

  localparam logic [31:0] TVEC_RESET = 32'h0000_0100;

  typedef struct packed {
    logic        take;
    logic        ret;
    logic [31:0] epc;
    logic [7:0]  cause;
  } hw_upd_t;

  function automatic logic [31:0] tvec_base(
    input logic [31:0] v
  );
    return {v[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/trap_csr_file.sv
// Supervisor trap CSRs: sstatus, stvec, sepc, scause.
// Software writes first, hardware trap/return updates override.
module trap_csr_file
  import trap_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        csr_we,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  input  hw_upd_t     upd,
  output logic [31:0] csr_rdata,
  output logic        sie,
  output logic [31:0] stvec,
  output logic [31:0] sepc
);

  logic       spie;
  logic [7:0] scause;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sie    <= 1'b0;
      spie   <= 1'b0;
      stvec  <= tvec_base(TVEC_RESET);
      sepc   <= '0;
      scause <= '0;
    end else begin
      if (csr_we) begin
        unique case (csr_addr)
          SSTATUS: begin
            sie  <= csr_wdata[SIE_BIT];
            spie <= csr_wdata[SPIE_BIT];
          end
          STVEC:  stvec  <= tvec_base(csr_wdata);
          SEPC:   sepc   <= csr_wdata;
          SCAUSE: scause <= csr_wdata[7:0];
          default: ;
        endcase
      end
      // later assignments win: hardware beats a colliding write
      if (upd.take) begin
        sepc   <= upd.epc;
        scause <= upd.cause;
        spie   <= sie;
        sie    <= 1'b0;
      end else if (upd.ret) begin
        sie  <= spie;
        spie <= 1'b1;
      end
    end
  end

  always_comb begin
    csr_rdata = '0;
    unique case (csr_addr)
      SSTATUS: begin
        csr_rdata[SIE_BIT]  = sie;
        csr_rdata[SPIE_BIT] = spie;
      end
      STVEC:   csr_rdata = stvec;
      SEPC:    csr_rdata = sepc;
      SCAUSE:  csr_rdata = {24'b0, scause};
      default: csr_rdata = '0;
    endcase
  end

endmodule

// File: rtl/trap_controller.sv
// Trap entry / return sequencer driving flush, stall and redirect.
// All pipeline controls decode from registered state only.
module trap_controller
  import trap_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        ex_int,
  input  logic [7:0]  ex_scause,
  input  logic        ex_mret,
  input  logic [31:0] ex_pc,
  input  logic        ext_irq,
  input  logic        csr_we,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata,
  output logic        stall,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        in_trap
);

  state_t      state_q;
  state_t      state_d;
  hw_upd_t     upd;
  logic        sie;
  logic [31:0] stvec;
  logic [31:0] sepc;
  logic        take_exc;
  logic        take_irq;
  logic        take_ret;

  trap_csr_file u_csr (
    .clk       (clk),
    .rst       (rst),
    .csr_we    (csr_we),
    .csr_addr  (csr_addr),
    .csr_wdata (csr_wdata),
    .upd       (upd),
    .csr_rdata (csr_rdata),
    .sie       (sie),
    .stvec     (stvec),
    .sepc      (sepc)
  );

  // one-hot event selects encode the priority
  assign take_exc = ex_valid & ex_int;
  assign take_irq = ex_valid & ~ex_int
                  & ext_irq & sie;
  assign take_ret = ex_valid & ~ex_int
                  & ~(ext_irq & sie) & ex_mret;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      in_trap <= 1'b0;
    end else begin
      state_q <= state_d;
      if (upd.take)
        in_trap <= 1'b1;
      else if (upd.ret)
        in_trap <= 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    upd     = '0;
    unique case (state_q)
      IDLE: begin
        unique case (1'b1)
          take_exc: begin
            upd.take  = 1'b1;
            upd.epc   = ex_pc;
            upd.cause = ex_scause;
            state_d   = T_FLUSH;
          end
          take_irq: begin
            upd.take  = 1'b1;
            upd.epc   = ex_pc;
            upd.cause = IRQ_CAUSE;
            state_d   = T_FLUSH;
          end
          take_ret: begin
            upd.ret = 1'b1;
            state_d = R_FLUSH;
          end
          default: ;
        endcase
      end
      T_FLUSH: state_d = T_REDIR;
      T_REDIR: state_d = IDLE;
      R_FLUSH: state_d = R_REDIR;
      R_REDIR: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    stall          = (state_q != IDLE);
    flush          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    unique case (state_q)
      T_FLUSH: flush = 1'b1;
      R_FLUSH: flush = 1'b1;
      T_REDIR: begin
        redirect_valid = 1'b1;
        redirect_pc    = tvec_base(stvec);
      end
      R_REDIR: begin
        redirect_valid = 1'b1;
        redirect_pc    = sepc;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_trap_controller.sv
// Scoreboard bench for trap_controller: stimulus queues expectations,
// a negedge monitor pops and compares them.
module tb_trap_controller;
  import trap_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic        ex_int;
  logic [7:0]  ex_scause;
  logic        ex_mret;
  logic [31:0] ex_pc;
  logic        ext_irq;
  logic        csr_we;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        stall;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        in_trap;

  trap_controller dut (
    .clk            (clk),
    .rst            (rst),
    .ex_valid       (ex_valid),
    .ex_int         (ex_int),
    .ex_scause      (ex_scause),
    .ex_mret        (ex_mret),
    .ex_pc          (ex_pc),
    .ext_irq        (ext_irq),
    .csr_we         (csr_we),
    .csr_addr       (csr_addr),
    .csr_wdata      (csr_wdata),
    .csr_rdata      (csr_rdata),
    .stall          (stall),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .in_trap        (in_trap)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] pc;
    int          cyc;
  } exp_t;

  typedef struct {
    string       name;
    logic [31:0] act;
    logic [31:0] exp;
  } chk_t;

  exp_t q[$];
  chk_t cq[$];
  int   checks = 0;
  int   errors = 0;
  int   flush_cyc = -10;

  always @(negedge clk) begin
    exp_t e;
    chk_t c;
    while (cq.size() > 0) begin
      c = cq.pop_front();
      checks++;
      if (c.act !== c.exp) begin
        errors++;
        $display("FAIL %s: got %h expected %h",
                 c.name, c.act, c.exp);
      end
    end
    if (!rst && flush) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL flush: unexpected at cyc %0d", cyc);
      end else begin
        flush_cyc = cyc;
      end
    end
    if (!rst && redirect_valid) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL redirect: unexpected pc=%h cyc=%0d",
                 redirect_pc, cyc);
      end else begin
        e = q.pop_front();
        if (redirect_pc !== e.pc || cyc != e.cyc ||
            flush_cyc != cyc - 1 || !stall) begin
          errors++;
          $display("FAIL redirect: pc=%h cyc=%0d fl=%0d st=%b, expected pc=%h cyc=%0d fl=%0d st=1",
                   redirect_pc, cyc, flush_cyc, stall,
                   e.pc, e.cyc, e.cyc - 1);
        end
      end
    end
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    cq.push_back('{name, act, exp});
  endtask

  task automatic rd(input string name,
                    input logic [11:0] addr,
                    input logic [31:0] exp);
    csr_addr = addr;
    #1;
    chk(name, csr_rdata, exp);
  endtask

  task automatic wr(input logic [11:0] addr,
                    input logic [31:0] data);
    @(posedge clk) #1;
    csr_we    = 1'b1;
    csr_addr  = addr;
    csr_wdata = data;
    @(posedge clk) #1;
    csr_we = 1'b0;
  endtask

  task automatic clr_ex();
    ex_valid  = 1'b0;
    ex_int    = 1'b0;
    ex_mret   = 1'b0;
    ext_irq   = 1'b0;
    ex_scause = '0;
    ex_pc     = '0;
  endtask

  task automatic issue(input logic [31:0] pc,
                       input logic [7:0] cause,
                       input logic i, input logic m,
                       input logic irq,
                       input logic exp_v,
                       input logic [31:0] exp_pc);
    @(posedge clk) #1;
    ex_valid  = 1'b1;
    ex_int    = i;
    ex_mret   = m;
    ext_irq   = irq;
    ex_scause = cause;
    ex_pc     = pc;
    @(posedge clk) #1;
    if (exp_v) q.push_back('{exp_pc, cyc + 1});
    clr_ex();
  endtask

  task automatic wait_done(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!stall && q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk) #1;
    chk({name, "_done"}, {31'b0, ok}, 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    csr_we = 1'b0;
    csr_addr = '0;
    csr_wdata = '0;
    clr_ex();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_stall", {31'b0, stall}, 0);
    chk("rst_flush", {31'b0, flush}, 0);
    chk("rst_rv", {31'b0, redirect_valid}, 0);
    rst = 1'b0;
    @(posedge clk) #1;
    chk("rst_rpc", redirect_pc, 0);
    chk("rst_intrap", {31'b0, in_trap}, 0);
    rd("rst_sstatus", SSTATUS, 32'h0);
    rd("rst_stvec", STVEC, 32'h100);
    rd("rst_sepc", SEPC, 32'h0);
    rd("rst_scause", SCAUSE, 32'h0);
    rd("bad_addr", 12'h7ff, 32'h0);

    issue(32'h40, ECALL, 1, 0, 0, 1, 32'h100);
    wait_done("ecall");
    rd("ecall_sepc", SEPC, 32'h40);
    rd("ecall_scause", SCAUSE, 32'h08);
    rd("ecall_sstatus", SSTATUS, 32'h0);
    chk("ecall_intrap", {31'b0, in_trap}, 1);

    wr(STVEC, 32'h2003);
    issue(32'h40, ILLEGAL, 1, 0, 0, 1, 32'h2000);
    wait_done("tvec");
    wr(SSTATUS, 32'h20);
    issue(32'h50, ECALL, 0, 1, 0, 1, 32'h40);
    wait_done("mret");
    rd("mret_sstatus", SSTATUS, 32'h22);
    chk("mret_intrap", {31'b0, in_trap}, 0);

    issue(32'h80, ECALL, 0, 0, 1, 1, 32'h2000);
    wait_done("irq");
    rd("irq_scause", SCAUSE, 32'h89);
    rd("irq_sepc", SEPC, 32'h80);
    rd("irq_sstatus", SSTATUS, 32'h20);
    wr(SSTATUS, 32'h0);
    issue(32'h90, ECALL, 0, 0, 1, 0, 32'h0);
    repeat (4) @(posedge clk);
    #1;
    chk("mask_stall", {31'b0, stall}, 0);
    rd("mask_sepc", SEPC, 32'h80);

    wr(SSTATUS, 32'h2);
    issue(32'hA0, MISALIGN, 1, 1, 1, 1, 32'h2000);
    wait_done("combo");
    rd("combo_scause", SCAUSE, 32'h00);
    rd("combo_sepc", SEPC, 32'hA0);
    rd("combo_sstatus", SSTATUS, 32'h20);

    @(posedge clk) #1;
    ex_valid = 1'b1;
    ex_int = 1'b1;
    ex_pc = 32'hB0;
    ex_scause = ECALL;
    @(posedge clk) #1;
    q.push_back('{32'h3000, cyc + 1});
    ex_pc = 32'hC4;
    ex_scause = ILLEGAL;
    csr_we = 1'b1;
    csr_addr = STVEC;
    csr_wdata = 32'h3000;
    @(posedge clk) #1;
    csr_we = 1'b0;
    @(posedge clk) #1;
    clr_ex();
    wait_done("dup");
    rd("dup_sepc", SEPC, 32'hB0);
    rd("dup_scause", SCAUSE, 32'h08);

    @(posedge clk) #1;
    ex_valid = 1'b1;
    ex_int = 1'b1;
    ex_pc = 32'hD2;
    ex_scause = ILLEGAL;
    csr_we = 1'b1;
    csr_addr = SEPC;
    csr_wdata = 32'h1234;
    @(posedge clk) #1;
    q.push_back('{32'h3000, cyc + 1});
    csr_we = 1'b0;
    clr_ex();
    wait_done("coll");
    rd("coll_sepc", SEPC, 32'hD2);
    rd("coll_scause", SCAUSE, 32'h02);

    @(posedge clk) #1;
    ex_valid = 1'b1;
    ex_int = 1'b1;
    ex_pc = 32'hE0;
    @(posedge clk) #1;
    clr_ex();
    q.push_back('{32'h3000, cyc + 1});
    @(negedge clk) #1;
    rst = 1'b1;
    q.delete();
    @(posedge clk) #1;
    chk("mid_stall", {31'b0, stall}, 0);
    chk("mid_flush", {31'b0, flush}, 0);
    chk("mid_rv", {31'b0, redirect_valid}, 0);
    chk("mid_rpc", redirect_pc, 0);
    chk("mid_intrap", {31'b0, in_trap}, 0);
    rd("mid_stvec", STVEC, 32'h100);
    rd("mid_sepc", SEPC, 32'h0);
    rd("mid_scause", SCAUSE, 32'h0);
    rd("mid_sstatus", SSTATUS, 32'h0);
    @(posedge clk) #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("sb_empty", q.size(), 0);
    repeat (3) @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
